// File: rtl/wb_regfile.sv
// Architectural register file fed by the MEM/WB write-back stage, with two read ports for ID.
// Define REGFILE_BYPASS_EN to let a same-cycle write show through on the read ports.
module wb_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write,
  input  logic [$clog2(NREG)-1:0]  write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     is_jal,
  input  logic [DATA_W-1:0]        pc_plus_4,
  input  logic [$clog2(NREG)-1:0]  read_reg1,
  input  logic [$clog2(NREG)-1:0]  read_reg2,
  output logic [DATA_W-1:0]        read_data1,
  output logic [DATA_W-1:0]        read_data2,
  output logic [31:0]              wb_count
);

  localparam int unsigned AW = $clog2(NREG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [31:0]       wb_count_q;

  logic              we;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic              commit;

  // JAL link write overrides whatever the normal write-back controls say.
  always_comb begin
    if (is_jal) begin
      we = 1'b1;
      wa = AW'(LINK_REG);
      wd = pc_plus_4;
    end else begin
      we = reg_write;
      wa = write_reg;
      wd = write_data;
    end
  end

  assign commit = we && (wa != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else if (commit) begin
      regs_q[wa] <= wd;
      wb_count_q <= wb_count_q + 32'd1;
    end
  end

  always_comb begin
    read_data1 = regs_q[read_reg1];
`ifdef REGFILE_BYPASS_EN
    if (commit && (read_reg1 == wa)) begin
      read_data1 = wd;
    end
`endif
    if (read_reg1 == '0) begin
      read_data1 = '0;
    end
  end

  always_comb begin
    read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (commit && (read_reg2 == wa)) begin
      read_data2 = wd;
    end
`endif
    if (read_reg2 == '0) begin
      read_data2 = '0;
    end
  end

  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations adapt to REGFILE_BYPASS_EN.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        is_jal;
  logic [31:0] pc_plus_4;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] wb_count;

  int total;
  int bad;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .is_jal     (is_jal),
    .pc_plus_4  (pc_plus_4),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; commits one write on the following posedge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    @(negedge clk);
    reg_write  = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'h0;
    is_jal     = 1'b0;
    pc_plus_4  = 32'h0;
    read_reg1  = 5'd5;
    read_reg2  = 5'd31;

    // Reset held
    repeat (2) @(negedge clk);
    check("rst_rd1", read_data1, 32'h0);
    check("rst_rd2", read_data2, 32'h0);
    check("rst_cnt", wb_count, 32'h0);
    rst = 1'b1;

    // 1: write to r0 discarded, not counted
    read_reg1 = 5'd0;
    wr(5'd0, 32'hDEAD_BEEF);
    #1;
    check("r0_read", read_data1, 32'h0);
    check("r0_cnt", wb_count, 32'h0);

    // 2: basic write/read on both ports
    @(negedge clk);
    wr(5'd5, 32'h1234_5678);
    read_reg1 = 5'd5;
    read_reg2 = 5'd5;
    #1;
    check("r5_p1", read_data1, 32'h1234_5678);
    check("r5_p2", read_data2, 32'h1234_5678);
    check("r5_cnt", wb_count, 32'd1);

    // 3: JAL forces r31 regardless of reg_write/write_reg
    @(negedge clk);
    wr(5'd7, 32'h0000_0077);
    is_jal     = 1'b1;
    reg_write  = 1'b0;
    write_reg  = 5'd7;
    write_data = 32'h0000_0099;
    pc_plus_4  = 32'h0000_0040;
    @(negedge clk);
    is_jal    = 1'b0;
    read_reg1 = 5'd31;
    read_reg2 = 5'd7;
    #1;
    check("jal_r31", read_data1, 32'h0000_0040);
    check("jal_r7", read_data2, 32'h0000_0077);
    check("jal_cnt", wb_count, 32'd3);

    // 4: same-cycle read of the write target
    @(negedge clk);
    wr(5'd9, 32'h0000_0011);
    reg_write  = 1'b1;
    write_reg  = 5'd9;
    write_data = 32'h0000_0022;
    read_reg1  = 5'd9;
    read_reg2  = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_pre", read_data1, 32'h0000_0022);
`else
    check("byp_pre", read_data1, 32'h0000_0011);
`endif
    check("byp_r0", read_data2, 32'h0);
    @(negedge clk);
    // we=0: controls are don't-care and must neither bypass nor commit
    reg_write  = 1'b0;
    write_reg  = 5'd9;
    write_data = 32'hFFFF_0000;
    read_reg2  = 5'd9;
    #1;
    check("byp_post", read_data1, 32'h0000_0022);
    check("we0_nobyp", read_data2, 32'h0000_0022);
    check("byp_cnt", wb_count, 32'd5);
    @(negedge clk);
    #1;
    check("we0_r9", read_data1, 32'h0000_0022);
    check("we0_cnt", wb_count, 32'd5);

    // 5: async reset mid-cycle with a write pending
    wr(5'd3, 32'h0000_00AA);
    read_reg1 = 5'd3;
    #1;
    check("r3_aa", read_data1, 32'h0000_00AA);
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'h0000_00BB;
    #1;
    rst = 1'b0;
    #1;
    check("arst_r3", read_data1, 32'h0);
    check("arst_cnt", wb_count, 32'h0);
    @(negedge clk);
    reg_write = 1'b0;
    rst       = 1'b1;
    #1;
    check("arst_r3_rel", read_data1, 32'h0);
    check("arst_cnt_rel", wb_count, 32'h0);

    // 6: counter wrap
    @(negedge clk);
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    #1;
    check("wrap_pre", wb_count, 32'hFFFF_FFFF);
    @(negedge clk);
    wr(5'd1, 32'h0000_1234);
    read_reg1 = 5'd1;
    #1;
    check("wrap_cnt", wb_count, 32'h0);
    check("wrap_r1", read_data1, 32'h0000_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural register file: the consumer end of the MEM/WB write-back interface.
- Accepts the registered write-back controls and data each cycle and commits them to 32 general registers.
- Serves two combinational read ports to the ID stage.
- Handles JAL link writes to r31, keeps r0 hardwired to zero, and keeps a committed-write counter for debug.

Parameters:
- DATA_W, 32, register and data width
- NREG, 32, number of registers; index width is log2(NREG) = 5
- LINK_REG, 31, destination forced on a JAL link write

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous active-low reset
- reg_write  input  1  write-back enable from MEM/WB
- write_reg  input  5  write-back destination index
- write_data  input  DATA_W  write-back data (ALU result or load data, already muxed)
- is_jal  input  1  current write-back is a JAL link
- pc_plus_4  input  DATA_W  link value used when is_jal=1
- read_reg1  input  5  ID read port 1 index
- read_reg2  input  5  ID read port 2 index
- read_data1  output  DATA_W  read port 1 data
- read_data2  output  DATA_W  read port 2 data
- wb_count  output  32  number of committed writes since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers and wb_count clear to 0.
  - Read outputs therefore return 0 for any index while reset is held.
- Effective write, computed combinationally each cycle:
  - if is_jal=1: we=1, wa=LINK_REG, wd=pc_plus_4. This applies regardless of reg_write and write_reg.
  - else: we=reg_write, wa=write_reg, wd=write_data.
- Commit: on rising clk with rst=1, if we=1 and wa!=0, reg[wa]<=wd. The write takes effect one cycle after it is presented.
- r0 rules:
  - writes to index 0 are discarded.
  - reads of index 0 return 0 always.
  - a write to r0 does not increment wb_count.
- wb_count:
  - increments by 1 on every committed write (we=1, wa!=0).
  - wraps 0xFFFFFFFF -> 0.
- Reads:
  - combinational: read_dataN = reg[read_regN], subject to the r0 rule and the bypass below.
  - Both ports may read the same index simultaneously.
- Reset mid-operation: an asynchronous assert wins over a same-edge write; no register retains the write.
- X-safety: when we=0, wa and wd are don't-care and must not affect state.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - same-cycle write-through: if we=1, wa!=0 and read_regN==wa, read_dataN=wd instead of the stored value.
  - Removes the WB->ID hazard; the hazard unit relies on this.
- Undefined:
  - reads return only the stored value, so a same-cycle read sees the old data.
  - The hazard unit must then stall one extra cycle.
  - r0 still reads as 0 in both builds.

Test Plan:
1. Reset and r0:
   - Stimulus: hold rst=0; release; reg_write=1, write_reg=0, write_data=0xDEADBEEF; read_reg1=0.
   - Required: read_data1=0, wb_count=0.
2. Basic write then read:
   - Stimulus: write r5=0x12345678; next cycle read_reg1=5, read_reg2=5.
   - Required: both ports=0x12345678, wb_count=1.
3. JAL override:
   - Stimulus: is_jal=1, reg_write=0, write_reg=7, pc_plus_4=0x00000040.
   - Required: after the edge r31=0x40, r7 unchanged, wb_count incremented.
4. Same-cycle read of write target:
   - Stimulus: r9 holds 0x11; present a write r9=0x22 with read_reg1=9 in the same cycle.
   - Required: with REGFILE_BYPASS_EN, read_data1=0x22 before the edge; without it, read_data1=0x11 before the edge and 0x22 after.
5. Async reset mid-write:
   - Stimulus: r3=0xAA; assert rst=0 mid-cycle with a write r3=0xBB pending.
   - Required: r3 reads 0 immediately and after release; wb_count=0.
6. Counter wrap:
   - Stimulus: force wb_count=0xFFFFFFFF; commit one write to r1.
   - Required: wb_count=0.
